// File: rtl/scope_capture_if.sv
// Bus bundle for scope_capture_buffer: ADC stream, trigger setup, read port, status.
// adc_valid is a valid-only qualifier: the buffer takes every valid sample, with no backpressure.
interface scope_capture_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              arm;
  logic [DATA_W-1:0] trig_level;
  logic              trig_slope;
  logic [15:0]       rd_addr;
  logic [15:0]       rd_data;
  logic              busy;
  logic              done;
  logic              trig_forced;
  logic [2:0]        dbg_state;

  modport master (
    output adc_data, adc_valid, arm, trig_level, trig_slope, rd_addr,
    input  rd_data, busy, done, trig_forced, dbg_state
  );

  modport slave (
    input  adc_data, adc_valid, arm, trig_level, trig_slope, rd_addr,
    output rd_data, busy, done, trig_forced, dbg_state
  );
endinterface

// File: rtl/scope_capture_buffer.sv
// Triggered circular sample capture for the scope datapath; freezes after the post-trigger fill.
// Optional forced trigger after AUTO_TIMEOUT idle cycles: define SCOPE_AUTO_TRIG_EN.
module scope_capture_buffer #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 10,
  parameter int PRE_SAMPLES  = 256,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            reset_n,
  scope_capture_if.slave  bus
);

  localparam int DEPTH        = 1 << ADDR_W;
  localparam int POST_SAMPLES = DEPTH - PRE_SAMPLES;

  if (DATA_W > 15 || PRE_SAMPLES < 0 || PRE_SAMPLES >= DEPTH || AUTO_TIMEOUT < 1) begin : g_bad_param
    $error("scope_capture_buffer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE_FILL  = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST_FILL = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] start_ptr;
  logic [ADDR_W:0]   pre_cnt;
  logic [ADDR_W:0]   post_cnt;
  logic [DATA_W-1:0] prev;
  logic              capturing;
  logic              we;
  logic              level_hit;
  logic              trig_hit;

  assign capturing = (state == S_PRE_FILL) || (state == S_WAIT_TRIG) || (state == S_POST_FILL);
  // A restart cycle writes nothing, so the new capture begins cleanly on the next sample.
  assign we        = capturing && bus.adc_valid && !bus.arm;

  assign level_hit = bus.trig_slope
                   ? ((prev > bus.trig_level) && (bus.adc_data <= bus.trig_level))
                   : ((prev < bus.trig_level) && (bus.adc_data >= bus.trig_level));

`ifdef SCOPE_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            forced_q;

  assign timeout_hit = (to_cnt == TO_W'(AUTO_TIMEOUT));
  assign trig_hit    = (state == S_WAIT_TRIG) && we && (level_hit || timeout_hit);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt   <= '0;
      forced_q <= 1'b0;
    end else begin
      if (state == S_WAIT_TRIG && !bus.arm) begin
        if (!timeout_hit) to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
      if (bus.arm)                    forced_q <= 1'b0;
      else if (trig_hit && !level_hit) forced_q <= 1'b1;
    end
  end

  assign bus.trig_forced = forced_q;
`else
  assign trig_hit        = (state == S_WAIT_TRIG) && we && level_hit;
  assign bus.trig_forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.arm) begin
      state_nxt = S_PRE_FILL;
    end else begin
      case (state)
        S_PRE_FILL: begin
          if (PRE_SAMPLES == 0)
            state_nxt = S_WAIT_TRIG;
          else if (we && pre_cnt == (ADDR_W+1)'(PRE_SAMPLES - 1))
            state_nxt = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (trig_hit) state_nxt = (POST_SAMPLES == 1) ? S_DONE : S_POST_FILL;
        end
        S_POST_FILL: begin
          if (we && post_cnt == (ADDR_W+1)'(POST_SAMPLES - 1)) state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      start_ptr <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      prev      <= '0;
    end else if (bus.arm) begin
      pre_cnt  <= '0;
      post_cnt <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        prev   <= bus.adc_data;
      end
      if (we && state == S_PRE_FILL) pre_cnt <= pre_cnt + (ADDR_W+1)'(1);
      // Trigger sample sits PRE_SAMPLES entries after start_ptr, i.e. at logical index PRE_SAMPLES.
      if (trig_hit) begin
        start_ptr <= wr_ptr - ADDR_W'(PRE_SAMPLES);
        post_cnt  <= (ADDR_W+1)'(1);
      end else if (we && state == S_POST_FILL) begin
        post_cnt <= post_cnt + (ADDR_W+1)'(1);
      end
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] rd_phys;
  logic              oor_q;
  logic              done_q;
  logic [15:0]       rd_word;
  logic [15:0]       rd_data_q;

  assign rd_phys = start_ptr + bus.rd_addr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= bus.adc_data;
    ram_q <= mem[rd_phys];
  end

  always_comb begin
    rd_word = '0;
    if (!oor_q) rd_word[DATA_W-1:0] = ram_q;
    rd_word[15] = done_q;
  end

  // Status bit travels with the RAM read so both land in rd_data on the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oor_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      oor_q     <= ({1'b0, bus.rd_addr} >= 17'(DEPTH));
      done_q    <= (state == S_DONE);
      rd_data_q <= rd_word;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = capturing;
  assign bus.done      = (state == S_DONE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Directed bench for scope_capture_buffer (DATA_W=12, ADDR_W=4, PRE_SAMPLES=4, AUTO_TIMEOUT=50).
module tb_scope_capture_buffer;
  localparam int DATA_W       = 12;
  localparam int ADDR_W       = 4;
  localparam int PRE_SAMPLES  = 4;
  localparam int AUTO_TIMEOUT = 50;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd;

  always #5 clk = ~clk;

  scope_capture_if #(.DATA_W(DATA_W)) cap ();

  scope_capture_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_SAMPLES(PRE_SAMPLES), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(cap)
  );

  // Drivers: inputs change 1 time unit after the rising edge, outputs are read there too.
  task automatic push(input logic [DATA_W-1:0] v);
    cap.adc_data  = v;
    cap.adc_valid = 1'b1;
    @(posedge clk); #1;
    cap.adc_valid = 1'b0;
  endtask

  task automatic do_arm();
    cap.arm = 1'b1;
    @(posedge clk); #1;
    cap.arm = 1'b0;
  endtask

  task automatic read_word(input logic [15:0] a, output logic [15:0] d);
    cap.rd_addr = a;
    repeat (2) @(posedge clk);
    #1;
    d = cap.rd_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cap.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", cap.busy); end
    checks++; if (cap.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", cap.done); end
    checks++; if (cap.trig_forced !== 1'b0) begin errors++; $display("FAIL reset_forced got %0b exp 0", cap.trig_forced); end
    checks++; if (cap.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", cap.dbg_state, ST_IDLE); end
    checks++; if (cap.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", cap.rd_data); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (cap.dbg_state !== ST_IDLE) begin errors++; $display("FAIL idle_hold got %0d exp %0d", cap.dbg_state, ST_IDLE); end
  endtask

  task automatic test_rising_ramp();
    cap.trig_level = 12'd550;
    cap.trig_slope = 1'b0;
    do_arm();
    checks++; if (cap.dbg_state !== ST_PRE) begin errors++; $display("FAIL ramp_arm_state got %0d exp %0d", cap.dbg_state, ST_PRE); end
    for (int i = 0; i < 4; i++) push(12'(i * 100));
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL ramp_prefill_done got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    push(12'd400);
    push(12'd500);
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL ramp_no_early_trig got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    push(12'd600);
    checks++; if (cap.dbg_state !== ST_POST) begin errors++; $display("FAIL ramp_trig got %0d exp %0d", cap.dbg_state, ST_POST); end
    for (int i = 7; i <= 16; i++) push(12'(i * 100));
    checks++; if (cap.done !== 1'b0 || cap.busy !== 1'b1) begin errors++; $display("FAIL ramp_post11 got done=%0b busy=%0b exp done=0 busy=1", cap.done, cap.busy); end
    push(12'd1700);
    checks++; if (cap.done !== 1'b1 || cap.busy !== 1'b0) begin errors++; $display("FAIL ramp_post12 got done=%0b busy=%0b exp done=1 busy=0", cap.done, cap.busy); end
    read_word(16'd4, rd);
    checks++; if (rd !== 16'h8258) begin errors++; $display("FAIL ramp_rd4 got %h exp 8258", rd); end
    cap.rd_addr = 16'd0;
    @(posedge clk); #1;
    checks++; if (cap.rd_data !== 16'h8258) begin errors++; $display("FAIL ramp_rd_latency1 got %h exp 8258", cap.rd_data); end
    @(posedge clk); #1;
    checks++; if (cap.rd_data !== 16'h80C8) begin errors++; $display("FAIL ramp_rd0 got %h exp 80c8", cap.rd_data); end
    read_word(16'd2, rd);
    checks++; if (rd !== 16'h8190) begin errors++; $display("FAIL ramp_rd2 got %h exp 8190", rd); end
    read_word(16'd15, rd);
    checks++; if (rd !== 16'h86A4) begin errors++; $display("FAIL ramp_rd15 got %h exp 86a4", rd); end
  endtask

  task automatic test_falling();
    cap.trig_level = 12'd3500;
    cap.trig_slope = 1'b1;
    do_arm();
    for (int i = 0; i < 4; i++) push(12'(4000 - i * 100));
    push(12'd3600);
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL fall_no_early_trig got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    push(12'd3500);
    checks++; if (cap.dbg_state !== ST_POST) begin errors++; $display("FAIL fall_trig got %0d exp %0d", cap.dbg_state, ST_POST); end
    for (int i = 0; i < 11; i++) push(12'(3400 - i * 100));
    checks++; if (cap.done !== 1'b1) begin errors++; $display("FAIL fall_done got %0b exp 1", cap.done); end
    read_word(16'd4, rd);
    checks++; if (rd !== 16'h8DAC) begin errors++; $display("FAIL fall_rd4 got %h exp 8dac", rd); end
    read_word(16'd0, rd);
    checks++; if (rd !== 16'h8F3C) begin errors++; $display("FAIL fall_rd0 got %h exp 8f3c", rd); end
    read_word(16'd15, rd);
    checks++; if (rd !== 16'h8960) begin errors++; $display("FAIL fall_rd15 got %h exp 8960", rd); end
    read_word(16'd20, rd);
    checks++; if (rd !== 16'h8000) begin errors++; $display("FAIL fall_rd_oor got %h exp 8000", rd); end
  endtask

  task automatic test_wrap();
    cap.trig_level = 12'd2000;
    cap.trig_slope = 1'b0;
    do_arm();
    for (int i = 1; i <= 40; i++) push(12'(i));
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL wrap_waiting got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    for (int i = 37; i <= 40; i++) exp_q.push_back(16'h8000 | 16'(i));
    for (int i = 0; i < 12; i++) begin
      push(12'(2000 + i));
      exp_q.push_back(16'h8000 | 16'(2000 + i));
    end
    checks++; if (cap.done !== 1'b1) begin errors++; $display("FAIL wrap_done got %0b exp 1", cap.done); end
    for (int a = 0; a < 16; a++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      read_word(16'(a), rd);
      checks++; if (rd !== e) begin errors++; $display("FAIL wrap_rd%0d got %h exp %h", a, rd, e); end
    end
  endtask

  task automatic test_arm_priority();
    cap.trig_level = 12'd550;
    cap.trig_slope = 1'b0;
    do_arm();
    for (int i = 0; i < 4; i++) push(12'd100);
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL prio_wait got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    cap.arm       = 1'b1;
    cap.adc_data  = 12'd1000;
    cap.adc_valid = 1'b1;
    @(posedge clk); #1;
    cap.arm       = 1'b0;
    cap.adc_valid = 1'b0;
    checks++; if (cap.dbg_state !== ST_PRE) begin errors++; $display("FAIL prio_restart got %0d exp %0d", cap.dbg_state, ST_PRE); end
    checks++; if (cap.busy !== 1'b1 || cap.done !== 1'b0) begin errors++; $display("FAIL prio_status got busy=%0b done=%0b exp busy=1 done=0", cap.busy, cap.done); end
    for (int i = 0; i < 4; i++) push(12'd100);
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL prio_refill got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    push(12'd1000);
    checks++; if (cap.dbg_state !== ST_POST) begin errors++; $display("FAIL prio_retrig got %0d exp %0d", cap.dbg_state, ST_POST); end
  endtask

  task automatic test_reset_mid_post();
    for (int i = 0; i < 3; i++) push(12'd1100);
    checks++; if (cap.dbg_state !== ST_POST) begin errors++; $display("FAIL midpost_pre got %0d exp %0d", cap.dbg_state, ST_POST); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (cap.busy !== 1'b0 || cap.done !== 1'b0) begin errors++; $display("FAIL midpost_status got busy=%0b done=%0b exp 0 0", cap.busy, cap.done); end
    checks++; if (cap.dbg_state !== ST_IDLE) begin errors++; $display("FAIL midpost_state got %0d exp %0d", cap.dbg_state, ST_IDLE); end
    checks++; if (cap.rd_data !== 16'h0000) begin errors++; $display("FAIL midpost_rd_data got %h exp 0000", cap.rd_data); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    cap.trig_level = 12'd550;
    cap.trig_slope = 1'b0;
    do_arm();
    for (int i = 0; i < 4; i++) push(12'd100);
`ifdef SCOPE_AUTO_TRIG_EN
    for (int i = 0; i < 61; i++) push(12'd100);
    checks++; if (cap.done !== 1'b0 || cap.trig_forced !== 1'b1) begin errors++; $display("FAIL auto_pre_done got done=%0b forced=%0b exp 0 1", cap.done, cap.trig_forced); end
    push(12'd100);
    checks++; if (cap.done !== 1'b1 || cap.trig_forced !== 1'b1) begin errors++; $display("FAIL auto_done got done=%0b forced=%0b exp 1 1", cap.done, cap.trig_forced); end
    read_word(16'd4, rd);
    checks++; if (rd !== 16'h8064) begin errors++; $display("FAIL auto_rd4 got %h exp 8064", rd); end
    do_arm();
    checks++; if (cap.trig_forced !== 1'b0) begin errors++; $display("FAIL auto_clear got %0b exp 0", cap.trig_forced); end
`else
    for (int i = 0; i < 200; i++) push(12'd100);
    checks++; if (cap.busy !== 1'b1 || cap.done !== 1'b0) begin errors++; $display("FAIL notimeout_status got busy=%0b done=%0b exp 1 0", cap.busy, cap.done); end
    checks++; if (cap.dbg_state !== ST_WAIT) begin errors++; $display("FAIL notimeout_state got %0d exp %0d", cap.dbg_state, ST_WAIT); end
    checks++; if (cap.trig_forced !== 1'b0) begin errors++; $display("FAIL notimeout_forced got %0b exp 0", cap.trig_forced); end
`endif
  endtask

  initial begin
    cap.adc_data   = '0;
    cap.adc_valid  = 1'b0;
    cap.arm        = 1'b0;
    cap.trig_level = '0;
    cap.trig_slope = 1'b0;
    cap.rd_addr    = '0;
    test_reset();
    test_rising_ramp();
    test_falling();
    test_wrap();
    test_arm_priority();
    test_reset_mid_post();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
